mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the SoC's single-port synchronous RAM between two CPU masters:
//  port 0 = instruction fetch, port 1 = load/store. Issues at most one RAM
//  access per cycle; round-robin on conflict; fully pipelined responses
//  tagged back to the issuing port after a fixed RAM read latency.
// PARAMETERS
//  AW        12  word-address width of RAM and of both master ports
//  MEM_LAT   1   RAM read latency in cycles, legal range 1..4
//  FIXED_PRI 0   0 = round-robin; 1 = port 1 always wins a conflict
// PORTS
//  clk        in   1    system clock; all logic on rising edge
//  resetn     in   1    synchronous, active-low reset
//  m0_req     in   1    port 0 request valid
//  m0_addr    in   AW   port 0 word address
//  m0_we      in   4    port 0 byte write enables; 4'b0000 = read
//  m0_wdata   in   32   port 0 write data
//  m0_gnt     out  1    port 0 request accepted this cycle (combinational)
//  m0_rvalid  out  1    port 0 response valid
//  m0_rdata   out  32   port 0 read data, 0 when m0_rvalid low
//  m1_*       ...  ...  identical set for port 1
//  mem_en     out  1    RAM access strobe
//  mem_we     out  4    RAM byte write enables
//  mem_addr   out  AW   RAM word address
//  mem_wdata  out  32   RAM write data
//  mem_rdata  in   32   RAM read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset (resetn=0 at clk edge): last_gnt<=1, owner pipeline cleared
//    (all tag valids 0); outputs m*_gnt=0, m*_rvalid=0, m*_rdata=0, mem_en=0,
//    mem_we=0 while resetn low. In-flight responses are dropped: no rvalid
//    for any access issued before reset.
//  - Handshake: master holds req, addr, we, wdata stable until gnt=1.
//    gnt is combinational from req and last_gnt; gnt=1 => accepted on that
//    edge; master may present a new request the very next cycle.
//  - Arbitration per cycle: only m0_req -> grant 0; only m1_req -> grant 1;
//    both -> FIXED_PRI=1: grant 1; else grant the port != last_gnt.
//    last_gnt updates only on a grant. Never both gnt in one cycle.
//  - Issue: on grant, mem_en=1 and mem_we/addr/wdata mux from winner in the
//    same cycle; with no grant mem_en=0, mem_we=0 (addr/wdata don't care).
//  - Response pipeline: MEM_LAT-stage shift register of {valid, port}.
//    Stage 0 loads {grant, winner} each cycle; stage MEM_LAT-1 drives
//    rvalid of its port. Response appears exactly MEM_LAT cycles after gnt.
//  - Writes also return an rvalid (ack) after MEM_LAT cycles; rdata is
//    mem_rdata (don't care to master). Reads: rdata = mem_rdata.
//  - Throughput: one access per cycle sustained; responses strictly in issue
//    order per port and globally; no stalls beyond arbitration loss.
//  - Starvation bound (FIXED_PRI=0): a continuously requesting port waits
//    at most 1 cycle.
//  - Widths: addresses pass unmodified, no wrap or bounds check; out-of-range
//    MEM_LAT is an elaboration error.
// TESTING
//  1 Reset: hold resetn=0 3 cycles with both req=1 -> gnt=0, mem_en=0,
//    rvalid=0; first cycle after release with both req -> m0_gnt=1.
//  2 Single read, MEM_LAT=1: m0 read addr 0x010, RAM holds 0xDEADBEEF ->
//    m0_gnt same cycle, m0_rvalid+rdata=0xDEADBEEF next cycle, m1_rvalid=0.
//  3 Contention, round-robin: both req for 6 cycles -> gnt order
//    0,1,0,1,0,1; rvalid follows same order MEM_LAT cycles later.
//  4 FIXED_PRI=1: both req 4 cycles -> m1_gnt 4 cycles, m0 none; m1 drops
//    -> m0 granted same cycle.
//  5 Write then read, MEM_LAT=3: m1 write we=4'b0011 data 0x12345678 to
//    0x020 (old 0xAAAAAAAA), m1 read 0x020 next cycle -> ack at +3,
//    read returns 0xAAAA5678 at +4.
//  6 Reset mid-flight, MEM_LAT=2: issue m0 read, assert resetn=0 next cycle
//    -> no m0_rvalid at all; post-reset traffic behaves as test 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous RAM between two CPU masters.
//   Port 0 is instruction fetch and port 1 is load/store. At most one RAM
//   access is issued per cycle, and conflicts are resolved round-robin or by
//   fixed priority to port 1. Every access, including writes, gets exactly one
//   response MEM_LAT cycles later, and the response is tagged back to the port
//   that issued it.
//
// Parameters
//   AW        word-address width of the RAM and of both master ports
//   MEM_LAT   RAM read latency in cycles (1..4)
//   FIXED_PRI 0 = round-robin, 1 = port 1 always wins a conflict
//
// Ports
//   clk, resetn                        clock, synchronous active-low reset
//   m0_req/addr/we/wdata               port 0 request (we == 0 means read)
//   m0_gnt                             port 0 accepted this cycle (comb.)
//   m0_rvalid/rdata                    port 0 response (rdata 0 when idle)
//   m1_*                               identical set for port 1
//   mem_en/we/addr/wdata               RAM access strobe and payload
//   mem_rdata                          RAM read data, MEM_LAT after mem_en
module mem_arbiter #(
  parameter int AW        = 12,
  parameter int MEM_LAT   = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_we,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_we,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // The response tag pipeline is only sized for the latencies the RAM can have
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..4");
  end

  logic               last_gnt;
  logic               grant;
  logic               winner;
  logic [MEM_LAT-1:0] tag_valid;
  logic [MEM_LAT-1:0] tag_port;
  logic               resp_valid;

  // Arbitration. The winner only matters when grant is high. When both ports
  // request, round-robin hands the slot to the port that did not win last
  // time. That is what bounds a continuously requesting port's wait to one
  // cycle. Grants are suppressed while in reset, so nothing is issued then.
  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    if (resetn) begin
      grant = m0_req | m1_req;
      if (m0_req && m1_req) begin
        if (FIXED_PRI != 0) begin
          winner = 1'b1;
        end else begin
          winner = ~last_gnt;
        end
      end else begin
        winner = m1_req;
      end
    end
  end

  assign m0_gnt = grant & ~winner;
  assign m1_gnt = grant & winner;

  // The winner's request goes straight to the RAM in the same cycle.
  // Write enables are forced low when idle so an idle cycle can never write.
  always_comb begin
    mem_en    = grant;
    mem_we    = 4'b0000;
    mem_addr  = winner ? m1_addr  : m0_addr;
    mem_wdata = winner ? m1_wdata : m0_wdata;
    if (grant) begin
      mem_we = winner ? m1_we : m0_we;
    end
  end

  // Round-robin history plus a {valid, port} shift register that mirrors the
  // RAM latency. A reset flushes the tags, so accesses issued before reset
  // never produce a response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_gnt  <= 1'b1;
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      if (grant) begin
        last_gnt <= winner;
      end
      tag_valid[0] <= grant;
      tag_port[0]  <= winner;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_port[i]  <= tag_port[i-1];
      end
    end
  end

  // The last tag stage lines up with mem_rdata. Read data is zeroed on the
  // port that is not being answered.
  assign resp_valid = resetn & tag_valid[MEM_LAT-1];
  assign m0_rvalid  = resp_valid & ~tag_port[MEM_LAT-1];
  assign m1_rvalid  = resp_valid & tag_port[MEM_LAT-1];
  assign m0_rdata   = m0_rvalid ? mem_rdata : 32'h0;
  assign m1_rdata   = m1_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed-vector bench for mem_arbiter. It builds four instances on one
//   clock, each with its own RAM model:
//     0: MEM_LAT=1, round-robin   (reset, single read, contention)
//     1: MEM_LAT=1, FIXED_PRI=1   (fixed priority)
//     2: MEM_LAT=3, round-robin   (byte-masked write then read)
//     3: MEM_LAT=2, round-robin   (reset while an access is in flight)
module tb_mem_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        resetn    [N];
  logic        m0_req    [N];
  logic [11:0] m0_addr   [N];
  logic [3:0]  m0_we     [N];
  logic [31:0] m0_wdata  [N];
  logic        m0_gnt    [N];
  logic        m0_rvalid [N];
  logic [31:0] m0_rdata  [N];
  logic        m1_req    [N];
  logic [11:0] m1_addr   [N];
  logic [3:0]  m1_we     [N];
  logic [31:0] m1_wdata  [N];
  logic        m1_gnt    [N];
  logic        m1_rvalid [N];
  logic [31:0] m1_rdata  [N];
  logic        mem_en    [N];
  logic [3:0]  mem_we    [N];
  logic [11:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];

  logic        ldEn      [N];
  logic [11:0] ldAddr    [N];
  logic [31:0] ldData    [N];

  int vecCount = 0;
  int errCount = 0;

  // Free-running 10 ns clock shared by every instance
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int LAT = (k == 2) ? 3 : ((k == 3) ? 2 : 1);
    localparam int FIX = (k == 1) ? 1 : 0;

    mem_arbiter #(.AW(12), .MEM_LAT(LAT), .FIXED_PRI(FIX)) u_dut (
      .clk       (clk),
      .resetn    (resetn[k]),
      .m0_req    (m0_req[k]),
      .m0_addr   (m0_addr[k]),
      .m0_we     (m0_we[k]),
      .m0_wdata  (m0_wdata[k]),
      .m0_gnt    (m0_gnt[k]),
      .m0_rvalid (m0_rvalid[k]),
      .m0_rdata  (m0_rdata[k]),
      .m1_req    (m1_req[k]),
      .m1_addr   (m1_addr[k]),
      .m1_we     (m1_we[k]),
      .m1_wdata  (m1_wdata[k]),
      .m1_gnt    (m1_gnt[k]),
      .m1_rvalid (m1_rvalid[k]),
      .m1_rdata  (m1_rdata[k]),
      .mem_en    (mem_en[k]),
      .mem_we    (mem_we[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata[k])
    );

    logic [31:0] ram    [0:4095];
    logic [31:0] rdPipe [0:LAT-1];

    // RAM model: reads return the pre-write contents, and the data comes out
    // LAT cycles after the strobe. The bench preloads through the ld port.
    always @(posedge clk) begin
      if (mem_en[k]) begin
        rdPipe[0] <= ram[mem_addr[k]];
        for (int b = 0; b < 4; b++) begin
          if (mem_we[k][b]) ram[mem_addr[k]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        end
      end
      for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
      if (ldEn[k]) ram[ldAddr[k]] <= ldData[k];
    end

    assign mem_rdata[k] = rdPipe[LAT-1];
  end

  // Compares one observed value with its expected value and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives both master ports of instance k
  task automatic applyStimulus(input int k,
                               input logic r0, input logic [11:0] a0,
                               input logic [3:0] w0, input logic [31:0] d0,
                               input logic r1, input logic [11:0] a1,
                               input logic [3:0] w1, input logic [31:0] d1);
    m0_req[k] = r0; m0_addr[k] = a0; m0_we[k] = w0; m0_wdata[k] = d0;
    m1_req[k] = r1; m1_addr[k] = a1; m1_we[k] = w1; m1_wdata[k] = d1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence. Inputs change 1 ns after each rising edge and outputs
  // are sampled on the falling edge.
  initial begin
    int expPort;
    int prevPort;

    for (int k = 0; k < N; k++) begin
      resetn[k] = 1'b0;
      applyStimulus(k, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    end
    ldEn[0] = 1'b1; ldAddr[0] = 12'h010; ldData[0] = 32'hDEADBEEF;
    ldEn[1] = 1'b1; ldAddr[1] = 12'h000; ldData[1] = 32'h00000000;
    ldEn[2] = 1'b1; ldAddr[2] = 12'h020; ldData[2] = 32'hAAAAAAAA;
    ldEn[3] = 1'b1; ldAddr[3] = 12'h010; ldData[3] = 32'hDEADBEEF;
    applyStimulus(0, 1, 12'h010, 4'h0, 32'h0, 1, 12'h030, 4'h0, 32'h0);
    nextCycle;
    for (int k = 0; k < N; k++) ldEn[k] = 1'b0;

    // Reset held with both ports requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst%0d m0_gnt", i), m0_gnt[0], 0);
      checkOutput($sformatf("rst%0d m1_gnt", i), m1_gnt[0], 0);
      checkOutput($sformatf("rst%0d mem_en", i), mem_en[0], 0);
      checkOutput($sformatf("rst%0d mem_we", i), mem_we[0], 0);
      checkOutput($sformatf("rst%0d rvalid", i), {m0_rvalid[0], m1_rvalid[0]}, 0);
      nextCycle;
    end
    for (int k = 0; k < N; k++) resetn[k] = 1'b1;
    @(negedge clk);
    checkOutput("rel m0_gnt", m0_gnt[0], 1);
    checkOutput("rel m1_gnt", m1_gnt[0], 0);
    nextCycle;
    applyStimulus(0, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("rel m0_rvalid", m0_rvalid[0], 1);
    checkOutput("rel m1_rvalid", m1_rvalid[0], 0);
    nextCycle;

    // Single read on port 0 with one-cycle latency
    applyStimulus(0, 1, 12'h010, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t2 m0_gnt", m0_gnt[0], 1);
    checkOutput("t2 m1_gnt", m1_gnt[0], 0);
    checkOutput("t2 mem_en", mem_en[0], 1);
    checkOutput("t2 mem_addr", mem_addr[0], 12'h010);
    checkOutput("t2 mem_we", mem_we[0], 0);
    nextCycle;
    applyStimulus(0, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t2 m0_rvalid", m0_rvalid[0], 1);
    checkOutput("t2 m0_rdata", m0_rdata[0], 32'hDEADBEEF);
    checkOutput("t2 m1_rvalid", m1_rvalid[0], 0);
    checkOutput("t2 idle mem_en", mem_en[0], 0);
    nextCycle;
    @(negedge clk);
    checkOutput("t2 m0_rvalid off", m0_rvalid[0], 0);
    checkOutput("t2 m0_rdata off", m0_rdata[0], 0);
    nextCycle;

    // Contention under round-robin. Port 1 is served once first so that
    // port 0 is next in line.
    applyStimulus(0, 0, 12'h0, 4'h0, 32'h0, 1, 12'h030, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t3 solo m1_gnt", m1_gnt[0], 1);
    checkOutput("t3 solo m0_gnt", m0_gnt[0], 0);
    nextCycle;
    applyStimulus(0, 1, 12'h010, 4'h0, 32'h0, 1, 12'h030, 4'h0, 32'h0);
    prevPort = 1;
    for (int i = 0; i < 6; i++) begin
      expPort = i % 2;
      @(negedge clk);
      checkOutput($sformatf("t3 c%0d m0_gnt", i), m0_gnt[0], expPort == 0);
      checkOutput($sformatf("t3 c%0d m1_gnt", i), m1_gnt[0], expPort == 1);
      checkOutput($sformatf("t3 c%0d m0_rvalid", i), m0_rvalid[0], prevPort == 0);
      checkOutput($sformatf("t3 c%0d m1_rvalid", i), m1_rvalid[0], prevPort == 1);
      prevPort = expPort;
      nextCycle;
    end
    applyStimulus(0, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t3 tail m1_rvalid", m1_rvalid[0], 1);
    checkOutput("t3 tail m0_rvalid", m0_rvalid[0], 0);
    nextCycle;

    // Fixed priority: port 1 wins every conflict, and port 0 gets the slot
    // as soon as port 1 stops requesting
    applyStimulus(1, 1, 12'h004, 4'h0, 32'h0, 1, 12'h008, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4 c%0d m1_gnt", i), m1_gnt[1], 1);
      checkOutput($sformatf("t4 c%0d m0_gnt", i), m0_gnt[1], 0);
      checkOutput($sformatf("t4 c%0d m1_rvalid", i), m1_rvalid[1], i > 0);
      nextCycle;
    end
    applyStimulus(1, 1, 12'h004, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t4 drop m0_gnt", m0_gnt[1], 1);
    checkOutput("t4 drop m1_gnt", m1_gnt[1], 0);
    checkOutput("t4 drop m1_rvalid", m1_rvalid[1], 1);
    nextCycle;
    applyStimulus(1, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t4 m0_rvalid", m0_rvalid[1], 1);
    checkOutput("t4 m1_rvalid off", m1_rvalid[1], 0);
    nextCycle;

    // Byte-masked write followed by a read with three-cycle latency
    applyStimulus(2, 0, 12'h0, 4'h0, 32'h0, 1, 12'h020, 4'b0011, 32'h12345678);
    @(negedge clk);
    checkOutput("t5 wr m1_gnt", m1_gnt[2], 1);
    checkOutput("t5 wr mem_we", mem_we[2], 4'b0011);
    checkOutput("t5 wr mem_wdata", mem_wdata[2], 32'h12345678);
    nextCycle;
    applyStimulus(2, 0, 12'h0, 4'h0, 32'h0, 1, 12'h020, 4'b0000, 32'h0);
    @(negedge clk);
    checkOutput("t5 rd m1_gnt", m1_gnt[2], 1);
    checkOutput("t5 rd mem_we", mem_we[2], 0);
    nextCycle;
    applyStimulus(2, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t5 +2 m1_rvalid", m1_rvalid[2], 0);
    nextCycle;
    @(negedge clk);
    checkOutput("t5 ack m1_rvalid", m1_rvalid[2], 1);
    checkOutput("t5 ack m0_rvalid", m0_rvalid[2], 0);
    nextCycle;
    @(negedge clk);
    checkOutput("t5 rd m1_rvalid", m1_rvalid[2], 1);
    checkOutput("t5 rd m1_rdata", m1_rdata[2], 32'hAAAA5678);
    nextCycle;
    @(negedge clk);
    checkOutput("t5 end m1_rvalid", m1_rvalid[2], 0);
    nextCycle;

    // Reset while a read is in flight: its response must be dropped
    applyStimulus(3, 1, 12'h010, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t6 m0_gnt", m0_gnt[3], 1);
    nextCycle;
    resetn[3] = 1'b0;
    @(negedge clk);
    checkOutput("t6 rst m0_gnt", m0_gnt[3], 0);
    checkOutput("t6 rst mem_en", mem_en[3], 0);
    nextCycle;
    resetn[3] = 1'b1;
    applyStimulus(3, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t6 drop m0_rvalid", m0_rvalid[3], 0);
    nextCycle;
    @(negedge clk);
    checkOutput("t6 drop2 m0_rvalid", m0_rvalid[3], 0);
    nextCycle;
    applyStimulus(3, 1, 12'h010, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t6 post m0_gnt", m0_gnt[3], 1);
    nextCycle;
    applyStimulus(3, 0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("t6 post +1 m0_rvalid", m0_rvalid[3], 0);
    nextCycle;
    @(negedge clk);
    checkOutput("t6 post m0_rvalid", m0_rvalid[3], 1);
    checkOutput("t6 post m0_rdata", m0_rdata[3], 32'hDEADBEEF);
    checkOutput("t6 post m1_rvalid", m1_rvalid[3], 0);
    nextCycle;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
